rob: RTL and testbench
======================

# rob

Reorder buffer: circular queue of in-flight instructions in the Tomasulo core. Allocates an entry per issued instruction and returns its ROB id for renaming. Answers the register file's two operand lookups by ROB id. Captures CDB results and retires entries in program order, presenting one commit per cycle back to the register file.

## Interface

Parameters:
- `ROB_LOG`, 4: log2 of entry count; `ROB_SIZE` = 16; ROB id width = `ROB_LOG`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rdy`  in  1  global enable; low = stall.
- `flush`  in  1  synchronous clear (mispredict).
- `is_valid`  in  1  issue requests an entry this cycle.
- `is_rd`  in  5  destination register of the issued instruction.
- `is_name`  out  `ROB_LOG`  id that will be allocated (current tail).
- `is_full`  out  1  no free entry; issue must stall.
- `reg_ord1`, `reg_ord2`  in  `ROB_LOG`  ids being looked up by the register file.
- `reg_rdy1`, `reg_rdy2`  out  1  looked-up entry holds a result.
- `reg_val1`, `reg_val2`  out  32  that result (0 when not ready).
- `cdb_valid`  in  1  result broadcast valid.
- `cdb_name`  in  `ROB_LOG`  producing entry id.
- `cdb_val`  in  32  result value.
- `cm_valid`  out  1  one-cycle commit pulse.
- `cm_rd`  out  5  committed destination register.
- `cm_val`  out  32  committed value.
- `cm_name`  out  `ROB_LOG`  committed id; register file clears busy only if its rename tag equals it.

## Operation

- Per entry: `busy`, `done`, `rd[4:0]`, `val[31:0]`.
- Pointers: `head`, `tail` (wrap modulo `ROB_SIZE`), plus `count` of width `ROB_LOG+1`.
- `is_full` = (`count` == `ROB_SIZE`), computed from registered count. A commit in the same cycle does not lift it.
- Allocate: when `is_valid` and `!is_full`, write entry[`tail`] with busy=1, done=0, rd=`is_rd`, val=0; `tail`++.
- Writeback: when `cdb_valid` and entry[`cdb_name`].busy, set done=1 and val=`cdb_val`. A writeback to a non-busy entry is ignored.
- Allocation and writeback to the same index in the same cycle: allocation wins.
- Lookup (combinational):
  - `reg_rdyN` = (busy && done) || (`cdb_valid` && `cdb_name`==`reg_ordN`).
  - `reg_valN` takes the CDB bypass first, then the stored val, else 0.
- Commit: when entry[`head`] is busy and done, register `cm_valid`=1 with its rd/val/name. Clear busy, `head`++.
  - x0 destinations still commit; the register file discards them.
- Count update: +1 on allocate, −1 on commit, net 0 when both happen.
- Priority: `rst` > `flush` > `rdy` low > normal.
  - `flush`: head=tail=count=0, all busy=0, `cm_valid`=0.
  - `rdy` low: all state holds except `cm_valid`, which clears so no commit is duplicated.

## Timing

- Reset (async): head=tail=count=0; all entries cleared.
- Outputs at reset: `is_name`=0, `is_full`=0, `reg_rdy*`=0, `reg_val*`=0, `cm_valid`=0, `cm_rd`=0, `cm_val`=0, `cm_name`=0.
- `is_name` and `is_full` are valid in the same cycle as the request. The entry exists from the next edge.
- CDB write at edge N into the head entry: `cm_valid` high during cycle N+1.
- CDB bypass to lookups has zero latency, in the same cycle as the broadcast.
- Maximum throughput: one allocate, one writeback, one commit per cycle.
- Full wrap: tail reaching `ROB_SIZE`−1 then allocating goes to 0. Empty is head==tail with count=0; full is head==tail with count=`ROB_SIZE`.

## Structure

- Shared defines file holds `ROB_SIZE`, the `ROBID` range macro, `True`/`False`, and 32-bit data width.
- The register file uses the same macros.
- Single module, no sub-module. Entry arrays are plain register arrays.

## Test plan

- Reset mid-run with 3 busy entries:
  - outputs go 0 immediately, without waiting for a clock edge;
  - after release, next allocate returns `is_name`=0.
- Allocate ids 0,1,2 with rd=5,6,7; CDB id1=0x11 then id0=0x22:
  - commit order is (5,0x22,id0), then (6,0x11,id1);
  - id2 is held until written.
- Lookup `reg_ord1`=3 with `cdb_valid` and `cdb_name`=3, `cdb_val`=0xDEAD in the same cycle: `reg_rdy1`=1 and `reg_val1`=0xDEAD.
- Fill to 16 entries: `is_full`=1 and a 17th `is_valid` does not change tail.
- Wrap-around: commit one from full, then allocate; the new `is_name` equals the old head id, 0 after the first lap.
- With entries busy and done, assert `rdy`=0 for 3 cycles, then `flush`:
  - `cm_valid` stays 0 throughout;
  - after flush, count=0 and `is_full`=0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer and its consumers.
package rob_pkg;

  localparam int ROB_LOG_DEFAULT = 4;
  localparam int DATA_W          = 32;
  localparam int REG_W           = 5;
  localparam bit TRUE            = 1'b1;
  localparam bit FALSE           = 1'b0;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_W-1:0]  reg_idx_t;

  // One in-flight instruction: busy = allocated, done = result captured.
  typedef struct packed {
    logic     busy;
    logic     done;
    reg_idx_t rd;
    data_t    val;
  } rob_entry_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions. Allocates at
// tail, captures CDB results by id, retires from head in program order.
//
// Issue handshake: is_valid is a request and is_full is the stall signal.
// An entry is allocated on a rising edge where is_valid && !is_full &&
// rdy && !flush hold; is_name is the id that allocation receives. is_full
// comes from the registered count, so a same-cycle commit does not lift it.
module rob
  import rob_pkg::*;
#(
  parameter int ROB_LOG = ROB_LOG_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               flush,
  input  logic               is_valid,
  input  logic [4:0]         is_rd,
  output logic [ROB_LOG-1:0] is_name,
  output logic               is_full,
  input  logic [ROB_LOG-1:0] reg_ord1,
  input  logic [ROB_LOG-1:0] reg_ord2,
  output logic               reg_rdy1,
  output logic               reg_rdy2,
  output logic [31:0]        reg_val1,
  output logic [31:0]        reg_val2,
  input  logic               cdb_valid,
  input  logic [ROB_LOG-1:0] cdb_name,
  input  logic [31:0]        cdb_val,
  output logic               cm_valid,
  output logic [4:0]         cm_rd,
  output logic [31:0]        cm_val,
  output logic [ROB_LOG-1:0] cm_name
);

  localparam int ROB_SIZE = 1 << ROB_LOG;
  localparam logic [ROB_LOG:0] COUNT_FULL = (ROB_LOG+1)'(ROB_SIZE);

  rob_entry_t         ent_q [ROB_SIZE];
  rob_entry_t         ent_d [ROB_SIZE];
  logic [ROB_LOG-1:0] head_q, head_d;
  logic [ROB_LOG-1:0] tail_q, tail_d;
  logic [ROB_LOG:0]   count_q, count_d;
  logic               cm_valid_q, cm_valid_d;
  reg_idx_t           cm_rd_q, cm_rd_d;
  data_t              cm_val_q, cm_val_d;
  logic [ROB_LOG-1:0] cm_name_q, cm_name_d;
  logic               alloc, commit;

  assign is_name  = tail_q;
  assign is_full  = (count_q == COUNT_FULL);
  assign cm_valid = cm_valid_q;
  assign cm_rd    = cm_rd_q;
  assign cm_val   = cm_val_q;
  assign cm_name  = cm_name_q;

  // Operand lookups: same-cycle CDB bypass first, then the stored result.
  always_comb begin
    reg_rdy1 = ent_q[reg_ord1].busy && ent_q[reg_ord1].done;
    reg_val1 = reg_rdy1 ? ent_q[reg_ord1].val : '0;
    if (cdb_valid && (cdb_name == reg_ord1)) begin
      reg_rdy1 = TRUE;
      reg_val1 = cdb_val;
    end
    reg_rdy2 = ent_q[reg_ord2].busy && ent_q[reg_ord2].done;
    reg_val2 = reg_rdy2 ? ent_q[reg_ord2].val : '0;
    if (cdb_valid && (cdb_name == reg_ord2)) begin
      reg_rdy2 = TRUE;
      reg_val2 = cdb_val;
    end
  end

  // Next state: writeback, then commit, then allocate (allocation wins).
  always_comb begin
    ent_d      = ent_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    cm_valid_d = FALSE;
    cm_rd_d    = cm_rd_q;
    cm_val_d   = cm_val_q;
    cm_name_d  = cm_name_q;
    alloc      = is_valid && !is_full;
    commit     = ent_q[head_q].busy && ent_q[head_q].done;
    if (flush) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        ent_d[i].busy = FALSE;
        ent_d[i].done = FALSE;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (rdy) begin
      if (cdb_valid && ent_q[cdb_name].busy) begin
        ent_d[cdb_name].done = TRUE;
        ent_d[cdb_name].val  = cdb_val;
      end
      if (commit) begin
        cm_valid_d          = TRUE;
        cm_rd_d             = ent_q[head_q].rd;
        cm_val_d            = ent_q[head_q].val;
        cm_name_d           = head_q;
        ent_d[head_q].busy  = FALSE;
        head_d              = head_q + 1'b1;
      end
      if (alloc) begin
        ent_d[tail_q].busy = TRUE;
        ent_d[tail_q].done = FALSE;
        ent_d[tail_q].rd   = is_rd;
        ent_d[tail_q].val  = '0;
        tail_d             = tail_q + 1'b1;
      end
      count_d = count_q + (ROB_LOG+1)'(alloc) - (ROB_LOG+1)'(commit);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) ent_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cm_valid_q <= FALSE;
      cm_rd_q    <= '0;
      cm_val_q   <= '0;
      cm_name_q  <= '0;
    end else begin
      ent_q      <= ent_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      cm_valid_q <= cm_valid_d;
      cm_rd_q    <= cm_rd_d;
      cm_val_q   <= cm_val_d;
      cm_name_q  <= cm_name_d;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed scenarios followed by random traffic, all checked
// against an in-order queue model of the instructions in flight.
module tb_rob;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        is_valid;
  logic [4:0]  is_rd;
  logic [3:0]  is_name;
  logic        is_full;
  logic [3:0]  reg_ord1, reg_ord2;
  logic        reg_rdy1, reg_rdy2;
  logic [31:0] reg_val1, reg_val2;
  logic        cdb_valid;
  logic [3:0]  cdb_name;
  logic [31:0] cdb_val;
  logic        cm_valid;
  logic [4:0]  cm_rd;
  logic [31:0] cm_val;
  logic [3:0]  cm_name;

  rob #(.ROB_LOG(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .is_valid(is_valid), .is_rd(is_rd), .is_name(is_name), .is_full(is_full),
    .reg_ord1(reg_ord1), .reg_ord2(reg_ord2),
    .reg_rdy1(reg_rdy1), .reg_rdy2(reg_rdy2),
    .reg_val1(reg_val1), .reg_val2(reg_val2),
    .cdb_valid(cdb_valid), .cdb_name(cdb_name), .cdb_val(cdb_val),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_val(cm_val), .cm_name(cm_name)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: program-order queue of (id, rd) plus results per id.
  typedef struct {
    logic [3:0] id;
    logic [4:0] rd;
  } ent_t;

  ent_t        ord_q[$];
  bit          m_done[16];
  logic [31:0] m_val[16];
  int          m_head;
  int          n_cmp;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_q(input logic [3:0] id);
    foreach (ord_q[i]) if (ord_q[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    ord_q.delete();
    m_head = 0;
  endtask

  task automatic chk_lookup(input string tag, input logic [3:0] o, input bit cv,
                            input logic [3:0] cn, input logic [31:0] cval,
                            input logic obs_rdy, input logic [31:0] obs_val);
    bit          e_rdy;
    logic [31:0] e_val;
    if (cv && cn == o) begin
      e_rdy = 1'b1; e_val = cval;
    end else if (in_q(o) && m_done[o]) begin
      e_rdy = 1'b1; e_val = m_val[o];
    end else begin
      e_rdy = 1'b0; e_val = '0;
    end
    chk({tag, "_rdy"}, 32'(obs_rdy), 32'(e_rdy));
    chk({tag, "_val"}, obs_val, e_val);
  endtask

  // Driver: one clock cycle of stimulus with pre-edge and post-edge checks.
  task automatic cycle(input bit v, input logic [4:0] rd, input bit cv,
                       input logic [3:0] cn, input logic [31:0] cval,
                       input bit r, input bit f,
                       input logic [3:0] o1, input logic [3:0] o2);
    bit          exp_cm;
    bit          was_full;
    ent_t        c;
    ent_t        n;
    logic [31:0] c_val;
    logic [3:0]  nid;
    is_valid = v; is_rd = rd; cdb_valid = cv; cdb_name = cn; cdb_val = cval;
    rdy = r; flush = f; reg_ord1 = o1; reg_ord2 = o2;
    #1;
    nid      = 4'((m_head + ord_q.size()) % 16);
    was_full = (ord_q.size() == 16);
    chk("is_name", 32'(is_name), 32'(nid));
    chk("is_full", 32'(is_full), 32'(was_full));
    chk_lookup("lk1", o1, cv, cn, cval, reg_rdy1, reg_val1);
    chk_lookup("lk2", o2, cv, cn, cval, reg_rdy2, reg_val2);
    exp_cm = 1'b0;
    c_val  = '0;
    c      = '{id: 4'd0, rd: 5'd0};
    if (f) begin
      model_clear();
    end else if (r) begin
      if (ord_q.size() > 0 && m_done[ord_q[0].id]) begin
        exp_cm = 1'b1;
        c      = ord_q[0];
        c_val  = m_val[c.id];
      end
      if (cv && in_q(cn)) begin
        m_done[cn] = 1'b1;
        m_val[cn]  = cval;
      end
      if (exp_cm) begin
        void'(ord_q.pop_front());
        m_head = (m_head + 1) % 16;
      end
      if (v && !was_full) begin
        n.id = nid; n.rd = rd;
        ord_q.push_back(n);
        m_done[nid] = 1'b0;
        m_val[nid]  = '0;
      end
    end
    @(posedge clk); #1;
    chk("cm_valid", 32'(cm_valid), 32'(exp_cm));
    if (exp_cm) begin
      chk("cm_rd", 32'(cm_rd), 32'(c.rd));
      chk("cm_val", cm_val, c_val);
      chk("cm_name", 32'(cm_name), 32'(c.id));
    end
  endtask

  task automatic idle();
    cycle(0, 5'd0, 0, 4'd0, 32'd0, 1, 0, 4'd0, 4'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_is_name"}, 32'(is_name), 32'd0);
    chk({tag, "_is_full"}, 32'(is_full), 32'd0);
    chk({tag, "_rdy1"}, 32'(reg_rdy1), 32'd0);
    chk({tag, "_val1"}, reg_val1, 32'd0);
    chk({tag, "_rdy2"}, 32'(reg_rdy2), 32'd0);
    chk({tag, "_val2"}, reg_val2, 32'd0);
    chk({tag, "_cm_valid"}, 32'(cm_valid), 32'd0);
    chk({tag, "_cm_rd"}, 32'(cm_rd), 32'd0);
    chk({tag, "_cm_val"}, cm_val, 32'd0);
    chk({tag, "_cm_name"}, 32'(cm_name), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    model_clear();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; is_valid = 1'b0; is_rd = '0;
    reg_ord1 = '0; reg_ord2 = '0; cdb_valid = 1'b0; cdb_name = '0; cdb_val = '0;
    #1;
    chk_all_zero("reset");
    @(posedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Mid-run reset with three busy entries; one of them already done.
    for (int i = 0; i < 4; i++) cycle(1, 5'(i + 1), 0, 4'd0, 32'd0, 1, 0, 4'd0, 4'd0);
    cycle(0, 5'd0, 1, 4'd0, 32'hAA, 1, 0, 4'd1, 4'd0);
    cycle(0, 5'd0, 1, 4'd1, 32'hBB, 1, 0, 4'd1, 4'd0);
    cdb_valid = 1'b0; reg_ord1 = 4'd1; reg_ord2 = 4'd1;
    #1;
    chk("pre_rst_rdy1", 32'(reg_rdy1), 32'd1);
    chk("pre_rst_cm_valid", 32'(cm_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    model_clear();
    @(posedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // In-order commit with out-of-order writeback.
    chk("post_rst_name", 32'(is_name), 32'd0);
    cycle(1, 5'd5, 0, 4'd0, 32'd0, 1, 0, 4'd0, 4'd1);
    cycle(1, 5'd6, 0, 4'd0, 32'd0, 1, 0, 4'd0, 4'd1);
    cycle(1, 5'd7, 0, 4'd0, 32'd0, 1, 0, 4'd0, 4'd1);
    cycle(0, 5'd0, 1, 4'd1, 32'h11, 1, 0, 4'd0, 4'd1);
    cycle(0, 5'd0, 1, 4'd0, 32'h22, 1, 0, 4'd0, 4'd1);
    cycle(0, 5'd0, 0, 4'd0, 32'd0, 1, 0, 4'd1, 4'd2);
    chk("ord_c0_rd", 32'(cm_rd), 32'd5);
    chk("ord_c0_val", cm_val, 32'h22);
    chk("ord_c0_name", 32'(cm_name), 32'd0);
    cycle(0, 5'd0, 0, 4'd0, 32'd0, 1, 0, 4'd1, 4'd2);
    chk("ord_c1_rd", 32'(cm_rd), 32'd6);
    chk("ord_c1_val", cm_val, 32'h11);
    chk("ord_c1_name", 32'(cm_name), 32'd1);
    idle();
    chk("id2_held", 32'(cm_valid), 32'd0);

    // Zero-latency CDB bypass on a lookup.
    is_valid = 1'b0; cdb_valid = 1'b1; cdb_name = 4'd3; cdb_val = 32'hDEAD; reg_ord1 = 4'd3;
    #1;
    chk("bypass_rdy1", 32'(reg_rdy1), 32'd1);
    chk("bypass_val1", reg_val1, 32'hDEAD);
    cycle(0, 5'd0, 1, 4'd3, 32'hDEAD, 1, 0, 4'd3, 4'd2);
    cycle(0, 5'd0, 1, 4'd2, 32'h33, 1, 0, 4'd2, 4'd3);
    idle();

    // Flush, fill to 16, reject a 17th, then wrap.
    cycle(0, 5'd0, 0, 4'd0, 32'd0, 1, 1, 4'd0, 4'd0);
    for (int i = 0; i < 16; i++) cycle(1, 5'($urandom_range(0, 31)), 0, 4'd0, 32'd0, 1, 0, 4'd0, 4'd0);
    chk("fill_full", 32'(is_full), 32'd1);
    cycle(1, 5'd9, 0, 4'd0, 32'd0, 1, 0, 4'd0, 4'd0);
    chk("no_17th_tail", 32'(is_name), 32'd0);
    chk("still_full", 32'(is_full), 32'd1);
    cycle(0, 5'd0, 1, 4'd0, 32'h44, 1, 0, 4'd0, 4'd0);
    idle();
    chk("wrap_name", 32'(is_name), 32'd0);
    chk("wrap_not_full", 32'(is_full), 32'd0);
    cycle(1, 5'd3, 0, 4'd0, 32'd0, 1, 0, 4'd0, 4'd0);

    // Stall with a ready head, then flush.
    cycle(0, 5'd0, 1, 4'd2, 32'h55, 1, 0, 4'd1, 4'd2);
    cycle(0, 5'd0, 1, 4'd3, 32'h66, 1, 0, 4'd1, 4'd2);
    cycle(0, 5'd0, 1, 4'd1, 32'h77, 1, 0, 4'd1, 4'd2);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 5'd0, 0, 4'd0, 32'd0, 0, 0, 4'd1, 4'd2);
      chk("stall_cm_valid", 32'(cm_valid), 32'd0);
    end
    cycle(0, 5'd0, 0, 4'd0, 32'd0, 1, 1, 4'd1, 4'd2);
    chk("flush_cm_valid", 32'(cm_valid), 32'd0);
    chk("flush_not_full", 32'(is_full), 32'd0);
    chk("flush_name", 32'(is_name), 32'd0);

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      bit         v, cv, r, f;
      logic [3:0] cn;
      v  = ($urandom_range(0, 99) < 55);
      cv = ($urandom_range(0, 99) < 50);
      r  = ($urandom_range(0, 99) >= 10);
      f  = ($urandom_range(0, 99) < 2);
      if (ord_q.size() > 0 && $urandom_range(0, 9) < 8)
        cn = ord_q[$urandom_range(0, ord_q.size() - 1)].id;
      else
        cn = 4'($urandom_range(0, 15));
      cycle(v, 5'($urandom_range(0, 31)), cv, cn, $urandom, r, f,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
